// File: rtl/latch_d_checker.sv
// Self-test sequencer for a D latch: forces Q low, applies a fixed vector set, scores Q/Q_ per vector.
// Latency STEP_CYCLES*(N+1)+1 edges from sampled i_start to o_done; N=4, or N=6 with LATCH_CHK_HOLD_EN.
// No backpressure: i_start is ignored while o_busy is high; results hold until the next start or reset.
module latch_d_checker #(
    parameter int STEP_CYCLES = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_cp,
    output logic       o_d,
    input  logic       i_q,
    input  logic       i_q_,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_count,
    output logic [2:0] o_fail_step
);

`ifdef LATCH_CHK_HOLD_EN
    localparam int N_VEC = 6;
`else
    localparam int N_VEC = 4;
`endif
    localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cyc;
    logic [2:0]    vec;
    logic [3:0]    err_count;
    logic [2:0]    fail_step;
    logic          last_cyc;
    logic          settle;
    logic          vec_cp, vec_d, vec_q;
    logic          mismatch;

    assign last_cyc = (cyc == CW'(STEP_CYCLES - 1));
    // One extra STEP cycle after the last vector lets o_done trail the final comparison by an edge.
    assign settle   = (vec == 3'(N_VEC));
    assign mismatch = (i_q != vec_q) || (i_q_ == i_q);

    always_comb begin
        vec_cp = 1'b0;
        vec_d  = 1'b0;
        vec_q  = 1'b0;
        case (vec)
            3'd0: vec_d = 1'b1;
            3'd1: vec_cp = 1'b1;
            3'd2: begin
                vec_cp = 1'b1;
                vec_d  = 1'b1;
                vec_q  = 1'b1;
            end
            3'd3: vec_q = 1'b1;
`ifdef LATCH_CHK_HOLD_EN
            3'd4: vec_cp = 1'b1;
            3'd5: vec_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start)  state_nxt = INIT;
            INIT:    if (last_cyc) state_nxt = STEP;
            STEP:    if (settle)   state_nxt = DONE;
            DONE:    if (i_start)  state_nxt = INIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cyc       <= '0;
            vec       <= '0;
            err_count <= '0;
            fail_step <= 3'd7;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        cyc       <= '0;
                        vec       <= '0;
                        err_count <= '0;
                        fail_step <= 3'd7;
                    end
                end
                INIT: begin
                    cyc <= last_cyc ? '0 : cyc + 1'b1;
                    vec <= '0;
                end
                STEP: begin
                    if (!settle) begin
                        cyc <= last_cyc ? '0 : cyc + 1'b1;
                        if (last_cyc) begin
                            vec <= vec + 3'd1;
                            if (mismatch) begin
                                if (err_count == 4'd0) fail_step <= vec;
                                if (err_count != 4'd15) err_count <= err_count + 4'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_cp   = 1'b0;
        o_d    = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state)
            INIT: begin
                o_cp   = 1'b1;
                o_busy = 1'b1;
            end
            STEP: begin
                o_cp   = vec_cp;
                o_d    = vec_d;
                o_busy = 1'b1;
            end
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_pass      = o_done && (err_count == 4'd0);
    assign o_err_count = err_count;
    assign o_fail_step = fail_step;

endmodule

// File: doc/latch_d_checker.md
LATCH_D_CHECKER -- requirements
Module: latch_d_checker

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 8, meaning clock cycles each vector is held (minimum 2).
REQ-002 SHALL have port i_clk  input  1  system clock, all logic on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset.
REQ-004 SHALL have port i_start  input  1  one-cycle pulse that begins a check run.
REQ-005 SHALL have port o_cp  output  1  enable driven to the latch under test.
REQ-006 SHALL have port o_d  output  1  data driven to the latch under test.
REQ-007 SHALL have port i_q  input  1  latch signal_q returned.
REQ-008 SHALL have port i_q_  input  1  latch signal_q_ returned.
REQ-009 SHALL have port o_busy  output  1  run in progress.
REQ-010 SHALL have port o_done  output  1  run finished; held until next start or reset.
REQ-011 SHALL have port o_pass  output  1  o_done and zero errors.
REQ-012 SHALL have port o_err_count  output  4  mismatch count, saturating.
REQ-013 SHALL have port o_fail_step  output  3  index of first failing vector; 3'd7 if none.
REQ-014 One clock; reset is synchronous and active-high.

Function
REQ-015 FSM states SHALL be IDLE, INIT, STEP, DONE.
REQ-016 IDLE -> INIT on i_start; INIT -> STEP after STEP_CYCLES cycles; STEP advances vector index after STEP_CYCLES cycles per vector; after last vector -> DONE; DONE -> INIT on i_start.
REQ-017 INIT SHALL drive o_cp=1, o_d=0 to force the latch to 0; no comparison in INIT.
REQ-018 Vectors (o_cp,o_d / expected q) SHALL be: 0: 0,1/0; 1: 1,0/0; 2: 1,1/1; 3: 0,0/1.
REQ-019 Comparison SHALL occur once per vector, in the last cycle of that vector (cycle counter = STEP_CYCLES-1).
REQ-020 Mismatch SHALL be i_q != expected OR i_q_ != ~i_q; each mismatch increments o_err_count, saturating at 15.
REQ-021 First mismatch SHALL load o_fail_step with the vector index; later mismatches leave it unchanged.
REQ-022 o_busy SHALL be 1 in INIT and STEP, 0 otherwise.
REQ-023 o_done SHALL rise on the edge after the final comparison, i.e. STEP_CYCLES*(N+1)+1 edges after the edge sampling i_start (N = vector count).
REQ-024 i_start while o_busy=1 SHALL be ignored.
REQ-025 i_start in DONE SHALL clear o_done, o_pass, o_err_count, o_fail_step (to 7) on the same edge it enters INIT.
REQ-026 In IDLE and DONE, o_cp=0 and o_d=0.

Reset
REQ-027 i_rst SHALL force state IDLE, o_cp=0, o_d=0, o_busy=0, o_done=0, o_pass=0, o_err_count=0, o_fail_step=7, counters 0.
REQ-028 i_rst SHALL take priority over i_start and abort any run in progress with no result reported.

Configuration
REQ-029 Macro LATCH_CHK_HOLD_EN defined SHALL append vectors 4: 1,0/0 and 5: 0,1/0 (N=6); undefined SHALL give N=4 exactly as REQ-018.

Verification
REQ-030 STEP_CYCLES=4, ideal latch model, macro off: pulse i_start -> o_done rises 21 edges later, o_pass=1, o_err_count=0, o_fail_step=7.
REQ-031 Same, macro on -> o_done at 29 edges, o_pass=1.
REQ-032 i_q stuck 0, i_q_=~i_q -> o_err_count=2, o_fail_step=2, o_pass=0.
REQ-033 Transparent-only model (i_q=o_d) -> o_err_count=2, o_fail_step=0.
REQ-034 i_q_ tied equal to i_q, ideal i_q -> o_err_count=4, o_fail_step=0.
REQ-035 i_rst asserted during vector 2 -> next edge all outputs at reset values; i_start pulses while o_busy=1 leave run timing unchanged.
